// File: rtl/param_ram.sv
// Parameterised single-port RAM that clears itself to CLEAR_VAL after reset or on request.
// Define RAM_WR_FWD_EN for write-first collisions; otherwise same-address read/write is read-first.
module param_ram #(
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 4,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_req,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_sweep_cnt;
    logic [ADDR_W-1:0] w_sweep_cnt_next;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_rd_fire;
    logic [DATA_W-1:0] w_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_CLEAR;
            r_sweep_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sweep_cnt <= w_sweep_cnt_next;
        end
    end

    // The sweep owns the memory port; user strobes only reach it in IDLE.
    always_comb begin
        w_state_next     = r_state;
        w_sweep_cnt_next = r_sweep_cnt;
        w_mem_we         = 1'b0;
        w_mem_addr       = address;
        w_mem_wdata      = data_in;
        w_rd_fire        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_mem_we         = 1'b1;
                w_mem_addr       = r_sweep_cnt;
                w_mem_wdata      = CLEAR_VAL;
                w_sweep_cnt_next = r_sweep_cnt + 1'b1;
                if (&r_sweep_cnt) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_mem_we         = wr_en;
                w_rd_fire        = rd_en;
                w_sweep_cnt_next = '0;
                if (clr_req) begin
                    w_state_next = ST_CLEAR;
                end
            end
            default: begin
                w_state_next     = ST_CLEAR;
                w_sweep_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

`ifdef RAM_WR_FWD_EN
    assign w_rd_data = wr_en ? data_in : r_mem[address];
`else
    assign w_rd_data = r_mem[address];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
    assign busy     = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_param_ram.sv
// Scoreboard bench for param_ram: default instance (a_) and an 8-bit/8-word instance
// with CLEAR_VAL=8'hFF (b_); monitors pop expected read data on each rd_valid pulse.
module tb_param_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_wr_en, a_rd_en, a_clr_req;
    logic [3:0]  a_address;
    logic [15:0] a_data_in, a_data_out;
    logic        a_rd_valid, a_busy;

    logic        b_rst, b_wr_en, b_rd_en, b_clr_req;
    logic [2:0]  b_address;
    logic [7:0]  b_data_in, b_data_out;
    logic        b_rd_valid, b_busy;

    param_ram u_dut_a (
        .clk      (clk),
        .rst      (a_rst),
        .wr_en    (a_wr_en),
        .rd_en    (a_rd_en),
        .address  (a_address),
        .data_in  (a_data_in),
        .clr_req  (a_clr_req),
        .data_out (a_data_out),
        .rd_valid (a_rd_valid),
        .busy     (a_busy)
    );

    param_ram #(.DATA_W(8), .ADDR_W(3), .CLEAR_VAL(8'hFF)) u_dut_b (
        .clk      (clk),
        .rst      (b_rst),
        .wr_en    (b_wr_en),
        .rd_en    (b_rd_en),
        .address  (b_address),
        .data_in  (b_data_in),
        .clr_req  (b_clr_req),
        .data_out (b_data_out),
        .rd_valid (b_rd_valid),
        .busy     (b_busy)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] a_q[$];
    logic [7:0]  b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (a_rd_valid === 1'b1) begin
            if (a_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_rd_valid: got rd_valid=1 expected no read pending");
            end else begin
                check("a_read", {16'h0, a_data_out}, {16'h0, a_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (b_rd_valid === 1'b1) begin
            if (b_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_rd_valid: got rd_valid=1 expected no read pending");
            end else begin
                check("b_read", {24'h0, b_data_out}, {24'h0, b_q.pop_front()});
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic a_write(input logic [3:0] addr, input logic [15:0] d);
        a_address = addr; a_data_in = d; a_wr_en = 1'b1;
        @(posedge clk); #1 a_wr_en = 1'b0;
    endtask

    task automatic a_read(input logic [3:0] addr, input logic [15:0] exp);
        a_address = addr; a_rd_en = 1'b1; a_q.push_back(exp);
        @(posedge clk); #1 a_rd_en = 1'b0;
    endtask

    task automatic b_write(input logic [2:0] addr, input logic [7:0] d);
        b_address = addr; b_data_in = d; b_wr_en = 1'b1;
        @(posedge clk); #1 b_wr_en = 1'b0;
    endtask

    task automatic b_read(input logic [2:0] addr, input logic [7:0] exp);
        b_address = addr; b_rd_en = 1'b1; b_q.push_back(exp);
        @(posedge clk); #1 b_rd_en = 1'b0;
    endtask

    // Counts cycles with busy=1; any strobes left asserted are dropped once busy falls.
    task automatic count_busy(input bit sel_b, input string name, input int exp);
        int n;
        n = 0;
        @(negedge clk);
        while (((sel_b ? b_busy : a_busy) === 1'b1) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (sel_b) begin b_wr_en = 1'b0; b_rd_en = 1'b0; end
        else begin a_wr_en = 1'b0; a_rd_en = 1'b0; end
        check(name, n, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        a_rst = 1'b1; a_wr_en = 1'b0; a_rd_en = 1'b0; a_clr_req = 1'b0;
        a_address = '0; a_data_in = '0;
        b_rst = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0; b_clr_req = 1'b0;
        b_address = '0; b_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("a_rst_data_out", {16'h0, a_data_out}, 32'h0);
        check("a_rst_rd_valid", {31'h0, a_rd_valid}, 32'h0);
        check("a_rst_busy", {31'h0, a_busy}, 32'h1);
        a_rst = 1'b0;
        count_busy(1'b0, "a_init_sweep_len", 16);

        for (int i = 0; i < 16; i++) a_read(4'(i), 16'h0000);

        a_write(4'd2, 16'h0005);
        a_read(4'd2, 16'h0005);
        a_read(4'd5, 16'h0000);
        a_write(4'd15, 16'hFFFF);
        a_write(4'd0, 16'h8001);
        a_read(4'd15, 16'hFFFF);
        a_read(4'd0, 16'h8001);
        repeat (3) @(posedge clk);
        #1 check("a_hold_data_out", {16'h0, a_data_out}, 32'h8001);

        // Read and clear on the same edge, then strobes and clr_req mid-sweep.
        a_write(4'd7, 16'hBEEF);
        a_address = 4'd7; a_rd_en = 1'b1; a_clr_req = 1'b1; a_q.push_back(16'hBEEF);
        @(posedge clk); #1 a_rd_en = 1'b0; a_clr_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a_address = 4'd3; a_data_in = 16'h1234; a_wr_en = 1'b1; a_rd_en = 1'b1; a_clr_req = 1'b1;
        @(posedge clk); #1 a_wr_en = 1'b0; a_rd_en = 1'b0; a_clr_req = 1'b0;
        count_busy(1'b0, "a_clr_no_restart_len", 11);
        check("a_hold_after_sweep", {16'h0, a_data_out}, 32'hBEEF);
        a_read(4'd7, 16'h0000);
        a_read(4'd3, 16'h0000);
        a_read(4'd2, 16'h0000);

        // Same-address read/write collision.
        a_write(4'd9, 16'h0011);
        a_address = 4'd9; a_data_in = 16'h00AA; a_wr_en = 1'b1; a_rd_en = 1'b1;
`ifdef RAM_WR_FWD_EN
        a_q.push_back(16'h00AA);
`else
        a_q.push_back(16'h0011);
`endif
        @(posedge clk); #1 a_wr_en = 1'b0; a_rd_en = 1'b0;
        a_read(4'd9, 16'h00AA);

        // Reset in the middle of a sweep.
        a_write(4'd4, 16'h5A5A);
        a_read(4'd4, 16'h5A5A);
        a_clr_req = 1'b1;
        @(posedge clk); #1 a_clr_req = 1'b0;
        repeat (6) @(posedge clk);
        #1 a_rst = 1'b1;
        #1;
        check("a_midrst_data_out", {16'h0, a_data_out}, 32'h0);
        check("a_midrst_rd_valid", {31'h0, a_rd_valid}, 32'h0);
        check("a_midrst_busy", {31'h0, a_busy}, 32'h1);
        @(posedge clk); #1 a_rst = 1'b0;
        a_address = 4'd1; a_data_in = 16'h7777; a_wr_en = 1'b1; a_rd_en = 1'b1;
        count_busy(1'b0, "a_resweep_len", 16);
        a_read(4'd1, 16'h0000);
        a_read(4'd4, 16'h0000);
        a_read(4'd12, 16'h0000);

        // Narrow instance with a non-zero clear value.
        check("b_rst_busy", {31'h0, b_busy}, 32'h1);
        check("b_rst_data_out", {24'h0, b_data_out}, 32'h0);
        b_rst = 1'b0;
        count_busy(1'b1, "b_sweep_len", 8);
        for (int i = 0; i < 8; i++) b_read(3'(i), 8'hFF);
        b_write(3'd7, 8'h3C);
        b_read(3'd7, 8'h3C);
        b_read(3'd6, 8'hFF);

        repeat (3) @(posedge clk);
        #1;
        check("a_queue_drained", a_q.size(), 0);
        check("b_queue_drained", b_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
- REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
- REQ-002 Parameter DATA_W, default 16, SHALL set the word width in bits.
- REQ-003 Parameter ADDR_W, default 4, SHALL set the address width; DEPTH SHALL be derived as 2**ADDR_W words.
- REQ-004 Parameter CLEAR_VAL, default 0, DATA_W bits, SHALL set the value written by a clear sweep.
- REQ-005 clk  input  1  rising-edge clock for all state.
- REQ-006 rst  input  1  asynchronous active-high reset.
- REQ-007 wr_en  input  1  write strobe.
- REQ-008 rd_en  input  1  read strobe.
- REQ-009 address  input  ADDR_W  word address shared by read and write.
- REQ-010 data_in  input  DATA_W  write data.
- REQ-011 clr_req  input  1  single-cycle request to start a clear sweep.
- REQ-012 data_out  output  DATA_W  registered read data.
- REQ-013 rd_valid  output  1  high for exactly one cycle when data_out carries new read data.
- REQ-014 busy  output  1  high while a clear sweep is in progress.

Function
- REQ-015 The FSM SHALL have two states: CLEAR and IDLE.
- REQ-016 In CLEAR, the block SHALL write CLEAR_VAL to one word per cycle, at addresses 0 to DEPTH-1 in ascending order, then enter IDLE on the edge that writes DEPTH-1.
- REQ-017 A sweep SHALL take exactly DEPTH cycles; busy SHALL be 1 throughout and SHALL go to 0 in the first IDLE cycle.
- REQ-018 In IDLE, clr_req=1 at a rising edge SHALL move the FSM to CLEAR with the sweep counter at 0.
- REQ-019 clr_req during CLEAR SHALL be ignored; the sweep SHALL NOT restart.
- REQ-020 In CLEAR, wr_en and rd_en SHALL be ignored: no memory update, rd_valid 0, data_out held.
- REQ-021 In IDLE, wr_en=1 at a rising edge SHALL store data_in at address.
- REQ-022 In IDLE, rd_en=1 at a rising edge SHALL load mem[address] into data_out at that edge, with rd_valid=1 for the following cycle (latency 1).
- REQ-023 data_out SHALL hold its last value when no read occurs.
- REQ-024 In IDLE, clr_req together with rd_en/wr_en on the same edge SHALL first perform the read/write, then enter CLEAR.
- REQ-025 Simultaneous wr_en and rd_en to different addresses SHALL both complete on the same edge.
- REQ-026 Address wrap SHALL be inherent: all ADDR_W-bit values are valid, and there SHALL be no out-of-range condition.

Reset
- REQ-027 Asserting rst SHALL immediately force data_out=0, rd_valid=0, busy=1, sweep counter=0 and state=CLEAR.
- REQ-028 After rst is released, a full DEPTH-cycle sweep SHALL run before the first access is accepted.
- REQ-029 rst asserted mid-sweep or mid-access SHALL abort the operation; the sweep SHALL restart from address 0 after release.

Configuration
- REQ-030 Macro RAM_WR_FWD_EN SHALL select collision behaviour.
- REQ-031 When RAM_WR_FWD_EN is defined, simultaneous wr_en and rd_en to the same address SHALL return data_in on data_out (write-first).
- REQ-032 When RAM_WR_FWD_EN is undefined, the same collision SHALL return the previous mem[address] (read-first); the write SHALL still occur.

Verification
- REQ-033 Default parameters: release rst at t0 -> busy=1 for exactly 16 cycles, then 0; reads at addresses 0..15 each return 0 with one rd_valid pulse.
- REQ-034 Write 5 to address 2, then read address 2 -> data_out=5 with rd_valid=1 one cycle after the read edge; a read of address 5 -> 0.
- REQ-035 Write 0xBEEF to address 7, pulse clr_req, and attempt a write of 0x1234 to address 3 at sweep cycle 4 -> after busy falls, address 7 reads 0 and address 3 reads 0.
- REQ-036 With address 9 holding 0x0011, apply wr_en=rd_en=1, address 9, data_in 0x00AA -> data_out=0x0011 without RAM_WR_FWD_EN, 0x00AA with it; a later read -> 0x00AA in both cases.
- REQ-037 Assert rst at sweep cycle 6 -> data_out=0, rd_valid=0 immediately; after release, busy=1 for a fresh 16 cycles.
- REQ-038 DATA_W=8, ADDR_W=3, CLEAR_VAL=8'hFF -> sweep lasts 8 cycles, all reads return 0xFF, and a write/read of 0x3C at address 7 returns 0x3C.
